// File: rtl/oled_spi_receiver.sv
// Purpose: decode the PmodOLEDrgb 4-wire SPI stream into command bytes and indexed RGB565 pixels.
// Latency: 1 clk from the clk edge that samples the 8th sclk-high to the valid pulse (3 clk with OLED_RX_SYNC_EN).
// Backpressure: none; the link cannot be stalled, so every output is a single-cycle pulse.
// Build option: define OLED_RX_SYNC_EN to put 2-flop synchronizers on cs/sclk/sdin/d_cn (board build).
module oled_spi_receiver #(
  parameter int FRAME_PIXELS = 6144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sclk,
  input  logic        sdin,
  input  logic        d_cn,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pix_valid,
  output logic [12:0] pix_index,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        byte_err
);

  localparam logic [12:0] LAST_IDX = 13'(FRAME_PIXELS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic        cs_s, sclk_s, sdin_s, d_cn_s;
  logic        sclk_d, sclk_rise;
  logic [2:0]  bit_cnt, cnt_nxt;
  logic [6:0]  shreg;
  logic [7:0]  rx_byte;
  logic        byte_done, err_nxt;
  logic        phase_lo;
  logic [7:0]  hi_byte;
  logic [12:0] idx;

`ifdef OLED_RX_SYNC_EN
  logic [1:0] cs_sync, sclk_sync, sdin_sync, dcn_sync;

  // Two-flop synchronizers; idle levels (cs/sclk high) come out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync   <= 2'b11;
      sclk_sync <= 2'b11;
      sdin_sync <= 2'b00;
      dcn_sync  <= 2'b00;
    end else begin
      cs_sync   <= {cs_sync[0], cs};
      sclk_sync <= {sclk_sync[0], sclk};
      sdin_sync <= {sdin_sync[0], sdin};
      dcn_sync  <= {dcn_sync[0], d_cn};
    end
  end

  assign cs_s   = cs_sync[1];
  assign sclk_s = sclk_sync[1];
  assign sdin_s = sdin_sync[1];
  assign d_cn_s = dcn_sync[1];
`else
  assign cs_s   = cs;
  assign sclk_s = sclk;
  assign sdin_s = sdin;
  assign d_cn_s = d_cn;
`endif

  // Delayed sclk copy for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sclk_d <= 1'b1;
    else       sclk_d <= sclk_s;
  end

  assign sclk_rise = sclk_s & ~sclk_d;

  // FSM state register plus bit counter and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      if (state == SHIFT && sclk_rise) shreg <= rx_byte[6:0];
    end
  end

  // Next state, byte completion and partial-byte detection. A cs rise in the
  // same cycle as the 8th sclk rise wraps the counter to 0, so no error.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    byte_done = 1'b0;
    err_nxt   = 1'b0;
    rx_byte   = {shreg, sdin_s};
    case (state)
      IDLE: begin
        cnt_nxt = 3'd0;
        if (!cs_s) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (sclk_rise) begin
          cnt_nxt   = bit_cnt + 3'd1;
          byte_done = (bit_cnt == 3'd7);
        end
        if (cs_s) begin
          state_nxt = IDLE;
          err_nxt   = (cnt_nxt != 3'd0);
          cnt_nxt   = 3'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Byte dispatch: commands resync the pixel phase/index, data pairs form pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_valid  <= 1'b0;
      cmd_byte   <= 8'h00;
      pix_valid  <= 1'b0;
      pix_index  <= 13'd0;
      pix_data   <= 16'h0000;
      frame_done <= 1'b0;
      byte_err   <= 1'b0;
      phase_lo   <= 1'b0;
      hi_byte    <= 8'h00;
      idx        <= 13'd0;
    end else begin
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      byte_err   <= err_nxt;
      if (byte_done) begin
        if (!d_cn_s) begin
          cmd_byte  <= rx_byte;
          cmd_valid <= 1'b1;
          phase_lo  <= 1'b0;
          idx       <= 13'd0;
        end else if (!phase_lo) begin
          hi_byte  <= rx_byte;
          phase_lo <= 1'b1;
        end else begin
          pix_data   <= {hi_byte, rx_byte};
          pix_index  <= idx;
          pix_valid  <= 1'b1;
          phase_lo   <= 1'b0;
          frame_done <= (idx == LAST_IDX);
          idx        <= (idx == LAST_IDX) ? 13'd0 : idx + 13'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver: drives SPI bytes, logs output pulses, checks against hand-computed values.
// A reduced frame size keeps the full-frame wrap test short.
module tb_oled_spi_receiver;

  localparam int FP   = 20;
  localparam int HALF = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b1, sclk = 1'b1, sdin = 1'b0, d_cn = 1'b0;
  logic        cmd_valid, pix_valid, frame_done, byte_err;
  logic [7:0]  cmd_byte;
  logic [12:0] pix_index;
  logic [15:0] pix_data;

  int n_cmp = 0, n_bad = 0;
  int n_cmd = 0, n_err = 0, n_frame = 0;
  logic [12:0] frame_idx = '0;
  logic [12:0] pidx_q[$];
  logic [15:0] pdat_q[$];

  oled_spi_receiver #(.FRAME_PIXELS(FP)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .sdin(sdin), .d_cn(d_cn),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pix_valid(pix_valid),
    .pix_index(pix_index), .pix_data(pix_data), .frame_done(frame_done),
    .byte_err(byte_err)
  );

  always #5 clk = ~clk;

  // Pulse logger, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid) n_cmd++;
      if (byte_err)  n_err++;
      if (pix_valid) begin
        pidx_q.push_back(pix_index);
        pdat_q.push_back(pix_data);
      end
      if (frame_done) begin
        n_frame++;
        frame_idx = pix_index;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) begin
      sclk = 1'b0; sdin = b[i]; d_cn = dc;
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic cs_open;
    cs = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_close;
    wait_clk(2);
    cs = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    int c0, e0, f0, p0;

    // Reset state
    wait_clk(3);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_byte", cmd_byte, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_index", pix_index, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_byte_err", byte_err, 0);
    reset = 1'b0;
    wait_clk(4);

    // Single command byte
    c0 = n_cmd; e0 = n_err; p0 = pidx_q.size();
    cs_open; spi_byte(8'hAF, 1'b0); cs_close;
    chk("cmd_count", n_cmd - c0, 1);
    chk("cmd_byte", cmd_byte, 8'hAF);
    chk("cmd_no_pix", pidx_q.size() - p0, 0);
    chk("cmd_no_err", n_err - e0, 0);

    // Command then two pixels in one cs window
    p0 = pidx_q.size();
    cs_open;
    spi_byte(8'h2C, 1'b0);
    spi_byte(8'hF8, 1'b1); spi_byte(8'h00, 1'b1);
    spi_byte(8'h07, 1'b1); spi_byte(8'hE0, 1'b1);
    cs_close;
    chk("px_count", pidx_q.size() - p0, 2);
    chk("px0_idx", pidx_q[p0], 0);
    chk("px0_dat", pdat_q[p0], 16'hF800);
    chk("px1_idx", pidx_q[p0+1], 1);
    chk("px1_dat", pdat_q[p0+1], 16'h07E0);

    // Full frame plus one pixel: index wraps at FP-1
    p0 = pidx_q.size(); f0 = n_frame;
    cs_open;
    spi_byte(8'h5C, 1'b0);
    for (int k = 0; k <= FP; k++) begin
      spi_byte(8'h00, 1'b1); spi_byte(8'h1F, 1'b1);
    end
    cs_close;
    chk("fr_count", pidx_q.size() - p0, FP + 1);
    chk("fr_done_count", n_frame - f0, 1);
    chk("fr_done_idx", frame_idx, FP - 1);
    chk("fr_first_idx", pidx_q[p0], 0);
    chk("fr_last_idx", pidx_q[p0+FP-1], FP - 1);
    chk("fr_wrap_idx", pidx_q[p0+FP], 0);
    chk("fr_wrap_dat", pdat_q[p0+FP], 16'h001F);

    // Partial byte then a good byte
    c0 = n_cmd; e0 = n_err; p0 = pidx_q.size();
    cs_open;
    for (int i = 0; i < 5; i++) begin
      sclk = 1'b0; sdin = 1'b1; wait_clk(HALF);
      sclk = 1'b1; wait_clk(HALF);
    end
    cs_close;
    chk("part_err", n_err - e0, 1);
    chk("part_no_cmd", n_cmd - c0, 0);
    chk("part_no_pix", pidx_q.size() - p0, 0);
    cs_open; spi_byte(8'h5A, 1'b0); cs_close;
    chk("part_next_cmd", cmd_byte, 8'h5A);
    chk("part_err_once", n_err - e0, 1);

    // Command in the middle of a pixel discards the high byte
    c0 = n_cmd; p0 = pidx_q.size();
    cs_open;
    spi_byte(8'h12, 1'b1);
    spi_byte(8'h15, 1'b0);
    spi_byte(8'hAB, 1'b1); spi_byte(8'hCD, 1'b1);
    cs_close;
    chk("mid_cmd_count", n_cmd - c0, 1);
    chk("mid_cmd_byte", cmd_byte, 8'h15);
    chk("mid_pix_count", pidx_q.size() - p0, 1);
    chk("mid_pix_idx", pidx_q[p0], 0);
    chk("mid_pix_dat", pdat_q[p0], 16'hABCD);

    // Async reset after a high byte; pixel index restarts
    c0 = n_cmd; e0 = n_err;
    cs_open;
    spi_byte(8'h99, 1'b1);
    reset = 1'b1;
    wait_clk(1);
    chk("ar_cmd_byte", cmd_byte, 0);
    chk("ar_pix_data", pix_data, 0);
    chk("ar_pix_index", pix_index, 0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(6);
    p0 = pidx_q.size();
    spi_byte(8'h34, 1'b1); spi_byte(8'h56, 1'b1);
    cs_close;
    chk("ar_pix_count", pidx_q.size() - p0, 1);
    chk("ar_pix_idx", pidx_q[p0], 0);
    chk("ar_pix_dat", pdat_q[p0], 16'h3456);
    chk("ar_no_err", n_err - e0, 0);
    chk("ar_no_cmd", n_cmd - c0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
